// File: rtl/ni_packetizer.sv
// ni_packetizer: turns a message descriptor plus payload words into a HEAD/BODY/TAIL wormhole flit stream.
// Latency: 1 cycle from a descriptor or data handshake to the matching flit on flit_o.
// Backpressure: msg_ready_o/data_ready_o follow the output register's free state (!flit_valid_o | flit_ready_i).
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   msg_valid_i/msg_ready_o            descriptor handshake (msg_x_i, msg_y_i, msg_len_i)
//   data_valid_i/data_ready_o          payload word handshake (data_i)
//   flit_o/flit_valid_o/flit_ready_i   registered flit output {flit_id[1:0], flit_data}
//   err_o                              one-cycle pulse after a zero-length descriptor
// Build option: define NI_SRC_ADDR_EN to place {X_CORD, Y_CORD} above the destination in the HEAD flit.
module ni_packetizer #(
    parameter int X_CORD          = 0,
    parameter int Y_CORD          = 0,
    parameter int PACKET_ADDR_X_W = 4,
    parameter int PACKET_ADDR_Y_W = 4,
    parameter int DATA_W          = 16,
    parameter int LEN_W           = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       msg_valid_i,
    output logic                       msg_ready_o,
    input  logic [PACKET_ADDR_X_W-1:0] msg_x_i,
    input  logic [PACKET_ADDR_Y_W-1:0] msg_y_i,
    input  logic [LEN_W-1:0]           msg_len_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    input  logic [DATA_W-1:0]          data_i,
    output logic [DATA_W+1:0]          flit_o,
    output logic                       flit_valid_o,
    input  logic                       flit_ready_i,
    output logic                       err_o
);

    localparam int XY_W = PACKET_ADDR_X_W + PACKET_ADDR_Y_W;

    localparam logic [1:0] ID_HEAD = 2'b01;
    localparam logic [1:0] ID_BODY = 2'b10;
    localparam logic [1:0] ID_TAIL = 2'b11;

    localparam logic [PACKET_ADDR_X_W-1:0] SRC_X = X_CORD[PACKET_ADDR_X_W-1:0];
    localparam logic [PACKET_ADDR_Y_W-1:0] SRC_Y = Y_CORD[PACKET_ADDR_Y_W-1:0];

`ifdef NI_SRC_ADDR_EN
    localparam logic SRC_EN = 1'b1;
`else
    localparam logic SRC_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic              out_free;
    logic              msg_hs;
    logic              data_hs;
    logic [DATA_W-1:0] head_dat;

    assign out_free     = !flit_valid_o || flit_ready_i;
    assign msg_ready_o  = (state == IDLE) && out_free;
    assign data_ready_o = (state == PAYLOAD) && out_free;
    assign msg_hs       = msg_valid_i && msg_ready_o;
    assign data_hs      = data_valid_i && data_ready_o;

    // Destination in the low field; source (when enabled) directly above; rest zero.
    always_comb begin
        head_dat                  = '0;
        head_dat[XY_W-1:0]        = {msg_x_i, msg_y_i};
        head_dat[2*XY_W-1:XY_W]   = SRC_EN ? {SRC_X, SRC_Y} : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            remaining    <= '0;
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            err_o <= 1'b0;
            // A load in the same cycle as a downstream accept simply replaces the flit.
            if (flit_ready_i) begin
                flit_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (msg_hs) begin
                        if (msg_len_i == '0) begin
                            // Descriptor is swallowed; no flit, only the error pulse.
                            err_o <= 1'b1;
                        end else begin
                            flit_o       <= {ID_HEAD, head_dat};
                            flit_valid_o <= 1'b1;
                            remaining    <= msg_len_i;
                            state        <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (data_hs) begin
                        flit_o       <= {(remaining == LEN_W'(1)) ? ID_TAIL : ID_BODY, data_i};
                        flit_valid_o <= 1'b1;
                        remaining    <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ni_packetizer.sv
module tb_ni_packetizer;

    logic        clk_i;
    logic        rst_ni;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [3:0]  msg_x_i;
    logic [3:0]  msg_y_i;
    logic [3:0]  msg_len_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [15:0] data_i;
    logic [17:0] flit_o;
    logic        flit_valid_o;
    logic        flit_ready_i;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    ni_packetizer #(
        .X_CORD(3), .Y_CORD(2),
        .PACKET_ADDR_X_W(4), .PACKET_ADDR_Y_W(4),
        .DATA_W(16), .LEN_W(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
        .msg_x_i(msg_x_i), .msg_y_i(msg_y_i), .msg_len_i(msg_len_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .flit_o(flit_o), .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready_i),
        .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

`ifdef NI_SRC_ADDR_EN
    localparam logic [7:0] SRC_FIELD = 8'h32;
`else
    localparam logic [7:0] SRC_FIELD = 8'h00;
`endif

    function automatic logic [17:0] head_exp(input logic [3:0] x, input logic [3:0] y);
        return {2'b01, SRC_FIELD, x, y};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_flit(input string name, input logic [17:0] exp);
        checks++;
        if (flit_valid_o !== 1'b1 || flit_o !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%b flit=%h, want valid=1 flit=%h", name, flit_valid_o, flit_o, exp);
        end
    endtask

    task automatic send_msg(input logic [3:0] x, input logic [3:0] y, input logic [3:0] len);
        msg_valid_i = 1'b1;
        msg_x_i = x;
        msg_y_i = y;
        msg_len_i = len;
        data_valid_i = 1'b0;
    endtask

    task automatic send_data(input logic [15:0] d);
        msg_valid_i = 1'b0;
        data_valid_i = 1'b1;
        data_i = d;
    endtask

    task automatic go_idle();
        msg_valid_i = 1'b0;
        data_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (flit_valid_o !== 1'b0 || flit_o !== 18'h0 || err_o !== 1'b0 ||
            msg_ready_o !== 1'b1 || data_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b f=%h err=%b mrdy=%b drdy=%b, want 0 0 0 1 0",
                     flit_valid_o, flit_o, err_o, msg_ready_o, data_ready_o);
        end
    endtask

    task automatic test_basic();
        flit_ready_i = 1'b1;
        send_msg(4'd2, 4'd1, 4'd3);
        tick();
        chk_flit("basic_head", head_exp(4'd2, 4'd1));
        send_data(16'hAAAA);
        #1;
        checks++;
        if (data_ready_o !== 1'b1 || msg_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_rdy: got drdy=%b mrdy=%b, want 1 0", data_ready_o, msg_ready_o);
        end
        tick();
        chk_flit("basic_a", {2'b10, 16'hAAAA});
        send_data(16'hBBBB);
        tick();
        chk_flit("basic_b", {2'b10, 16'hBBBB});
        send_data(16'hCCCC);
        tick();
        chk_flit("basic_c_tail", {2'b11, 16'hCCCC});
        go_idle();
        tick();
        checks++;
        if (flit_valid_o !== 1'b0 || msg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_drain: got v=%b mrdy=%b, want 0 1", flit_valid_o, msg_ready_o);
        end
    endtask

    task automatic test_stall();
        flit_ready_i = 1'b1;
        send_msg(4'd2, 4'd1, 4'd3);
        tick();
        send_data(16'h0A0A);
        tick();
        send_data(16'h0B0B);
        tick();
        chk_flit("stall_b_first", {2'b10, 16'h0B0B});
        flit_ready_i = 1'b0;
        send_data(16'h0C0C);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (data_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_drdy cycle %0d: got %b, want 0", i, data_ready_o);
            end
            tick();
            chk_flit("stall_hold_b", {2'b10, 16'h0B0B});
        end
        flit_ready_i = 1'b1;
        tick();
        chk_flit("stall_tail_c", {2'b11, 16'h0C0C});
        go_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        flit_ready_i = 1'b1;
        send_msg(4'd1, 4'd2, 4'd1);
        tick();
        chk_flit("b2b_head1", head_exp(4'd1, 4'd2));
        send_data(16'h1111);
        tick();
        chk_flit("b2b_tail1", {2'b11, 16'h1111});
        send_msg(4'd4, 4'd5, 4'd1);
        tick();
        chk_flit("b2b_head2", head_exp(4'd4, 4'd5));
        send_data(16'h2222);
        tick();
        chk_flit("b2b_tail2", {2'b11, 16'h2222});
        go_idle();
        tick();
    endtask

    task automatic test_zero_len();
        flit_ready_i = 1'b1;
        send_msg(4'd7, 4'd7, 4'd0);
        tick();
        checks++;
        if (err_o !== 1'b1 || flit_valid_o !== 1'b0 || msg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_pulse: got err=%b v=%b mrdy=%b, want 1 0 1", err_o, flit_valid_o, msg_ready_o);
        end
        go_idle();
        tick();
        checks++;
        if (err_o !== 1'b0 || flit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: got err=%b v=%b, want 0 0", err_o, flit_valid_o);
        end
    endtask

    task automatic test_src_addr();
        logic [17:0] exp;
`ifdef NI_SRC_ADDR_EN
        exp = 18'h13210;
`else
        exp = 18'h10010;
`endif
        flit_ready_i = 1'b1;
        send_msg(4'd1, 4'd0, 4'd1);
        tick();
        chk_flit("src_addr_head", exp);
        send_data(16'h5A5A);
        tick();
        chk_flit("src_addr_tail", {2'b11, 16'h5A5A});
        go_idle();
        tick();
    endtask

    task automatic test_reset_mid_packet();
        flit_ready_i = 1'b1;
        send_msg(4'd3, 4'd3, 4'd4);
        tick();
        send_data(16'hDEAD);
        tick();
        chk_flit("mid_body", {2'b10, 16'hDEAD});
        go_idle();
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (flit_valid_o !== 1'b0 || msg_ready_o !== 1'b1 || data_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b mrdy=%b drdy=%b, want 0 1 0", flit_valid_o, msg_ready_o, data_ready_o);
        end
        tick();
        #2;
        rst_ni = 1'b1;
        tick();
        send_msg(4'd6, 4'd9, 4'd1);
        tick();
        chk_flit("post_reset_head", head_exp(4'd6, 4'd9));
        send_data(16'hBEEF);
        tick();
        chk_flit("post_reset_tail", {2'b11, 16'hBEEF});
        go_idle();
        tick();
    endtask

    initial begin
        rst_ni = 1'b0;
        msg_valid_i = 1'b0;
        msg_x_i = '0;
        msg_y_i = '0;
        msg_len_i = '0;
        data_valid_i = 1'b0;
        data_i = '0;
        flit_ready_i = 1'b1;
        #23;
        test_reset();
        rst_ni = 1'b1;
        tick();
        test_basic();
        test_stall();
        test_back_to_back();
        test_zero_len();
        test_src_addr();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ni_packetizer.md
# ni_packetizer

Network-interface transmitter between a local resource (core) and the RESOURCE input port of the XY mesh router at (X_CORD, Y_CORD). The block accepts a message descriptor and a stream of payload words, and emits a wormhole packet as a flit stream toward the router. A packet is one HEAD flit carrying the destination x/y address the router decodes, then one flit per payload word, with the final word marked TAIL. Output is registered with valid/ready flow control and can send packets back-to-back at full throughput.

## Interface
- X_CORD, 0, own mesh column; source address in the header.
- Y_CORD, 0, own mesh row; source address in the header.
- PACKET_ADDR_X_W, 4, x address width.
- PACKET_ADDR_Y_W, 4, y address width.
- DATA_W, 16, flit payload width; must be ≥ 2·(PACKET_ADDR_X_W+PACKET_ADDR_Y_W).
- LEN_W, 4, payload length field width; max packet = 2^LEN_W−1 payload words.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- msg_valid_i  in  1  descriptor valid.
- msg_ready_o  out  1  descriptor accepted when msg_valid_i & msg_ready_o.
- msg_x_i  in  PACKET_ADDR_X_W  destination x.
- msg_y_i  in  PACKET_ADDR_Y_W  destination y.
- msg_len_i  in  LEN_W  payload word count.
- data_valid_i  in  1  payload word valid.
- data_ready_o  out  1  payload word accepted on data_valid_i & data_ready_o.
- data_i  in  DATA_W  payload word.
- flit_o  out  2+DATA_W  {flit_id[1:0], flit_data}.
- flit_valid_o  out  1  flit_o valid.
- flit_ready_i  in  1  router accepts flit on flit_valid_o & flit_ready_i.
- err_o  out  1  one-cycle pulse on a zero-length descriptor.

## Operation
- flit_id encoding: 2'b00 reserved/never sent, 2'b01 HEAD, 2'b10 BODY, 2'b11 TAIL.
- HEAD data: bits [X_W+Y_W−1:0] = {dst_x, dst_y}, dst_x in the upper field; higher bits depend on NI_SRC_ADDR_EN; remaining bits zero.
- Output register is free (out_free) when !flit_valid_o | flit_ready_i.
- FSM: IDLE, PAYLOAD.
- IDLE: msg_ready_o = out_free. On a descriptor handshake with msg_len_i ≠ 0, load the HEAD flit into the output register, set remaining = msg_len_i, and go to PAYLOAD.
- IDLE, msg_len_i = 0: the descriptor is consumed, no flit is produced, err_o pulses on the next cycle, and the state stays IDLE.
- PAYLOAD: data_ready_o = out_free; msg_ready_o = 0. On a data handshake, load {remaining==1 ? TAIL : BODY, data_i} and decrement remaining. When remaining==1, return to IDLE.
- data_ready_o = 0 in IDLE. err_o = 0 otherwise.
- When neither handshake loads the output register: if flit_ready_i, clear flit_valid_o; otherwise hold flit_o and flit_valid_o stable.
- remaining is LEN_W bits wide and never wraps; the payload word count always equals msg_len_i.

## Timing
- Reset values: state IDLE, flit_valid_o 0, flit_o 0, remaining 0, err_o 0. msg_ready_o resets to 1 and data_ready_o to 0 (combinational from reset state).
- Latency: 1 cycle from a descriptor handshake to HEAD on flit_o, and 1 cycle from a data handshake to its flit.
- Throughput: 1 flit/cycle with flit_ready_i held high. A packet of N words occupies N+1 cycles, and the next HEAD may follow the TAIL on the next cycle.
- A load and a downstream accept in the same cycle: the new flit replaces the old one with flit_valid_o staying 1.
- Reset mid-packet: the partial packet is abandoned immediately and asynchronously. The router must be reset together with this block.

## Configuration
- NI_SRC_ADDR_EN defined: HEAD data bits [2(X_W+Y_W)−1 : X_W+Y_W] = {X_CORD, Y_CORD}, truncated to their widths.
- NI_SRC_ADDR_EN undefined: those bits are zero.
- Every other behaviour is identical in both configurations.

## Test plan
- Reset, then descriptor (x=2,y=1,len=3) with words A,B,C and flit_ready_i=1 -> HEAD data 0x21, then BODY A, BODY B, TAIL C on consecutive cycles.
- Same packet with flit_ready_i low for 3 cycles during BODY B -> flit_o holds B stably, no word is lost, and data_ready_o=0 throughout the stall.
- Two descriptors back-to-back, len=1 each -> HEAD, TAIL, HEAD, TAIL with no idle cycle.
- Descriptor with len=0 -> err_o high for exactly one cycle and no flit_valid_o.
- Build with NI_SRC_ADDR_EN, X_CORD=3, Y_CORD=2, dest (1,0) -> HEAD data 0x3210; build without it -> 0x0010.
- rst_ni asserted low after the BODY flit of a len=4 packet -> flit_valid_o=0 at once; after release, a new packet starts cleanly with a HEAD flit.
